// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundles the read ports, the write port and the pending-write scoreboard
//   controls of regfile_scoreboard.
//
//   Handshake: there is no valid/ready back-pressure on any port. Every
//   wr_en, pend_set and flush strobe is consumed on the rising edge where it
//   is high. rd_ready is not a handshake signal; it reports whether the
//   value on a read port is architecturally current.
//
//   Signals (master = decode/datapath side, slave = register file):
//     rd_addr   [NUM_RD*ADDR_W]  read addresses, port k at [k*ADDR_W +: ADDR_W]
//     rd_data   [NUM_RD*DATA_W]  combinational read data, port k at [k*DATA_W +: DATA_W]
//     rd_ready  [NUM_RD]         1 = port k value is not awaiting a write
//     wr_en, wr_addr, wr_data    write port
//     pend_set, pend_addr        mark a register as awaiting a write
//     flush                      clear all pending marks
//     pend_cnt  [ADDR_W+1]       number of registers currently pending
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     flush;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, flush,
        input  rd_data, rd_ready, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, flush,
        output rd_data, rd_ready, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised register file with a per-register pending-write scoreboard.
//   Posedge writes, NUM_RD combinational read ports, optional same-cycle
//   write-to-read bypass and optional hardwired-zero register 0. Loads and
//   other multi-cycle producers mark their destination pending at issue; the
//   write-back clears the mark so decode can stall on rd_ready.
//
//   Ports:
//     clock  sole clock, all state updates on the rising edge
//     reset  synchronous, active-high; clears regs, pending marks and count
//     bus    regfile_scoreboard_if.slave (read, write, scoreboard controls)
//
//   Parameters DATA_W / ADDR_W / NUM_RD must match those of the connected
//   interface instance.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                  clock,
    input logic                  reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [ADDR_W:0]   pendCnt;

    logic wrZero;
    logic setZero;
    logic wrHit;
    logic setHit;
    logic setRise;
    logic wrFall;

    // Effective write/mark strobes and the pend-bit transitions they cause.
    // The count is stepped from these transitions rather than recomputed.
    always_comb begin
        wrZero  = (ZERO_REG != 0) && (bus.wr_addr == '0);
        setZero = (ZERO_REG != 0) && (bus.pend_addr == '0);
        wrHit   = bus.wr_en && !wrZero;
        // A flush squashes any mark issued in the same cycle.
        setHit  = bus.pend_set && !bus.flush && !setZero;
        setRise = setHit && !pend[bus.pend_addr];
        // A same-address mark is a newer producer, so the bit does not fall.
        wrFall  = wrHit && pend[bus.wr_addr] &&
                  !(setHit && (bus.pend_addr == bus.wr_addr));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrHit) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            pend    <= '0;
            pendCnt <= '0;
        end else begin
            if (wrHit) begin
                pend[bus.wr_addr] <= 1'b0;
            end
            // Placed after the clear so a same-address mark wins.
            if (setHit) begin
                pend[bus.pend_addr] <= 1'b1;
            end
            pendCnt <= pendCnt + {{ADDR_W{1'b0}}, setRise}
                               - {{ADDR_W{1'b0}}, wrFall};
        end
    end

    // Read ports: zero register first, then bypass, then stored state.
    logic [ADDR_W-1:0]        rdAddrA [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rdDataV;
    logic [NUM_RD-1:0]        rdReadyV;

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rdAddrA[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rdDataV  = '0;
        rdReadyV = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((ZERO_REG != 0) && (rdAddrA[k] == '0)) begin
                rdDataV[k*DATA_W +: DATA_W] = '0;
                rdReadyV[k]                 = 1'b1;
            end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == rdAddrA[k])) begin
                rdDataV[k*DATA_W +: DATA_W] = bus.wr_data;
                rdReadyV[k]                 = 1'b1;
            end else begin
                rdDataV[k*DATA_W +: DATA_W] = regs[rdAddrA[k]];
                rdReadyV[k]                 = !pend[rdAddrA[k]];
            end
        end
    end

    assign bus.rd_data  = rdDataV;
    assign bus.rd_ready = rdReadyV;
    assign bus.pend_cnt = pendCnt;
endmodule
